// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline control for the PC, IF/ID, ID/EX and EX/MEM registers.
// Detects load-use hazards, squashes wrong-path work on taken branches, freezes on
// data-memory stalls and parks the core on HALT. Tracks a saturating stall-cycle
// count and a memory-wait watchdog whose expiry raises a sticky error.
//
// Ports:
//   clk, rst (async, active-low)
//   id_rs/id_rt/id_rs_used/id_rt_used       decode-stage source operands
//   idex_mem_read/idex_reg_write/idex_wr_sel EX-stage destination info
//   branch_taken, imem_stall, dmem_stall, halt_mem   pipeline events
//   pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we   Mealy controls
//   stall_count (CNT_W), err                                    registered status
module pipe_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       id_rs,
    input  logic [2:0]       id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic             idex_mem_read,
    input  logic             idex_reg_write,
    input  logic [2:0]       idex_wr_sel,
    input  logic             branch_taken,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    input  logic             halt_mem,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_flush,
    output logic             exmem_we,
    output logic [CNT_W-1:0] stall_count,
    output logic             err
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALTED   = 2'd2
    } stateE;

    stateE            state;
    stateE            stateNext;
    logic [CNT_W-1:0] watchdog;
    logic [CNT_W-1:0] watchdogNext;
    logic             errNext;
    logic             loadUse;

    // Load in EX whose destination is read by the instruction in decode.
    assign loadUse = idex_mem_read & idex_reg_write &
                     ((id_rs_used & (id_rs == idex_wr_sel)) |
                      (id_rt_used & (id_rt == idex_wr_sel)));

    // Next-state, watchdog/error update and Mealy pipeline controls.
    always_comb begin
        stateNext    = state;
        watchdogNext = watchdog;
        errNext      = err;
        pc_we        = 1'b0;
        ifid_we      = 1'b0;
        ifid_flush   = 1'b0;
        idex_we      = 1'b0;
        idex_flush   = 1'b0;
        exmem_we     = 1'b0;

        case (state)
            RUN: begin
                if (halt_mem) begin
                    stateNext = HALTED;
                end else if (dmem_stall) begin
                    stateNext    = MEM_WAIT;
                    watchdogNext = CNT_W'(1);
                end else if (branch_taken) begin
                    pc_we      = 1'b1;
                    ifid_we    = 1'b1;
                    ifid_flush = 1'b1;
                    idex_we    = 1'b1;
                    idex_flush = 1'b1;
                    exmem_we   = 1'b1;
                end else if (loadUse) begin
                    // Hold PC and IF/ID, inject one bubble behind the load.
                    idex_we    = 1'b1;
                    idex_flush = 1'b1;
                    exmem_we   = 1'b1;
                end else if (imem_stall) begin
                    // Let the pipe drain; IF/ID receives a NOP.
                    ifid_we    = 1'b1;
                    ifid_flush = 1'b1;
                    idex_we    = 1'b1;
                    exmem_we   = 1'b1;
                end else begin
                    pc_we    = 1'b1;
                    ifid_we  = 1'b1;
                    idex_we  = 1'b1;
                    exmem_we = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (dmem_stall) begin
                    // Watchdog holds at TIMEOUT once expired; error stays sticky.
                    if (watchdog == CNT_W'(TIMEOUT)) begin
                        errNext = 1'b1;
                    end else begin
                        watchdogNext = watchdog + CNT_W'(1);
                    end
                end else begin
                    // Exit cycle releases everything; hazards are re-evaluated next cycle.
                    stateNext    = RUN;
                    watchdogNext = '0;
                    pc_we        = 1'b1;
                    ifid_we      = 1'b1;
                    idex_we      = 1'b1;
                    exmem_we     = 1'b1;
                end
            end
            HALTED: begin
                stateNext = HALTED;
            end
            default: begin
                errNext   = 1'b1;
                stateNext = RUN;
            end
        endcase

        // Reset forces the pipeline registers to hold and flush.
        if (!rst) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            ifid_flush = 1'b1;
            idex_we    = 1'b0;
            idex_flush = 1'b1;
            exmem_we   = 1'b0;
        end
    end

    // State, watchdog, error and saturating stall counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            watchdog    <= '0;
            err         <= 1'b0;
            stall_count <= '0;
        end else begin
            state    <= stateNext;
            watchdog <= watchdogNext;
            err      <= errNext;
            if (((state == RUN) || (state == MEM_WAIT)) && !pc_we &&
                (stall_count != {CNT_W{1'b1}})) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Inputs change just after the falling edge;
// Mealy controls and registered status are sampled 1 time unit later.
// Control vector bit order: {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we}.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [2:0] id_rs, id_rt, idex_wr_sel;
    logic       id_rs_used, id_rt_used, idex_mem_read, idex_reg_write;
    logic       branch_taken, imem_stall, dmem_stall, halt_mem;

    logic        pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, err;
    logic [15:0] stall_count;
    logic        pcWe4, ifidWe4, ifidFlush4, idexWe4, idexFlush4, exmemWe4, err4;
    logic [15:0] stallCount4;
    logic        pcWeS, ifidWeS, ifidFlushS, idexWeS, idexFlushS, exmemWeS, errS;
    logic [2:0]  stallCountS;

    wire [5:0] ctl = {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we};

    int tests = 0;
    int fails = 0;

    localparam logic [5:0] C_RESET = 6'b001010;
    localparam logic [5:0] C_RUN   = 6'b110101;
    localparam logic [5:0] C_LU    = 6'b000111;
    localparam logic [5:0] C_BR    = 6'b111111;
    localparam logic [5:0] C_IMEM  = 6'b011101;
    localparam logic [5:0] C_HOLD  = 6'b000000;

    pipe_hazard_ctrl #(.TIMEOUT(64), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .idex_mem_read(idex_mem_read), .idex_reg_write(idex_reg_write),
        .idex_wr_sel(idex_wr_sel), .branch_taken(branch_taken),
        .imem_stall(imem_stall), .dmem_stall(dmem_stall), .halt_mem(halt_mem),
        .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
        .idex_we(idex_we), .idex_flush(idex_flush), .exmem_we(exmem_we),
        .stall_count(stall_count), .err(err)
    );

    pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut4 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .idex_mem_read(idex_mem_read), .idex_reg_write(idex_reg_write),
        .idex_wr_sel(idex_wr_sel), .branch_taken(branch_taken),
        .imem_stall(imem_stall), .dmem_stall(dmem_stall), .halt_mem(halt_mem),
        .pc_we(pcWe4), .ifid_we(ifidWe4), .ifid_flush(ifidFlush4),
        .idex_we(idexWe4), .idex_flush(idexFlush4), .exmem_we(exmemWe4),
        .stall_count(stallCount4), .err(err4)
    );

    pipe_hazard_ctrl #(.TIMEOUT(7), .CNT_W(3)) dutS (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .idex_mem_read(idex_mem_read), .idex_reg_write(idex_reg_write),
        .idex_wr_sel(idex_wr_sel), .branch_taken(branch_taken),
        .imem_stall(imem_stall), .dmem_stall(dmem_stall), .halt_mem(halt_mem),
        .pc_we(pcWeS), .ifid_we(ifidWeS), .ifid_flush(ifidFlushS),
        .idex_we(idexWeS), .idex_flush(idexFlushS), .exmem_we(exmemWeS),
        .stall_count(stallCountS), .err(errS)
    );

    task automatic clear_inputs();
        id_rs = 3'd0; id_rt = 3'd0; id_rs_used = 1'b0; id_rt_used = 1'b0;
        idex_mem_read = 1'b0; idex_reg_write = 1'b0; idex_wr_sel = 3'd0;
        branch_taken = 1'b0; imem_stall = 1'b0; dmem_stall = 1'b0; halt_mem = 1'b0;
    endtask

    task automatic set_load(input logic [2:0] sel);
        idex_mem_read = 1'b1; idex_reg_write = 1'b1; idex_wr_sel = sel;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        dmem_stall = 1'b1;
        branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            if (ctl !== C_RESET) begin $display("FAIL reset_ctl[%0d]: got %b expected %b", i, ctl, C_RESET); fails++; end
            tests++;
            if (stall_count !== 16'd0 || err !== 1'b0) begin
                $display("FAIL reset_status[%0d]: got count=%0d err=%b expected count=0 err=0", i, stall_count, err); fails++;
            end
            tests++;
        end
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        #1;
        if (ctl !== C_RUN) begin $display("FAIL reset_release_ctl: got %b expected %b", ctl, C_RUN); fails++; end
        tests++;
        @(negedge clk); #1;
        if (stall_count !== 16'd0 || err !== 1'b0) begin
            $display("FAIL reset_release_status: got count=%0d err=%b expected count=0 err=0", stall_count, err); fails++;
        end
        tests++;
    endtask

    task automatic test_load_use();
        // Starts with stall_count 0 in RUN.
        @(negedge clk); set_load(3'd3); id_rs = 3'd3; id_rs_used = 1'b1; #1;
        if (ctl !== C_LU) begin $display("FAIL load_use_rs_ctl: got %b expected %b", ctl, C_LU); fails++; end
        tests++;
        if (stall_count !== 16'd0) begin $display("FAIL load_use_count_before: got %0d expected 0", stall_count); fails++; end
        tests++;
        @(negedge clk); clear_inputs(); #1;
        if (ctl !== C_RUN) begin $display("FAIL load_use_next_ctl: got %b expected %b", ctl, C_RUN); fails++; end
        tests++;
        if (stall_count !== 16'd1) begin $display("FAIL load_use_count_after: got %0d expected 1", stall_count); fails++; end
        tests++;
        @(negedge clk); set_load(3'd5); id_rt = 3'd5; id_rt_used = 1'b1; id_rs = 3'd2; id_rs_used = 1'b1; #1;
        if (ctl !== C_LU) begin $display("FAIL load_use_rt_ctl: got %b expected %b", ctl, C_LU); fails++; end
        tests++;
        // Matching rs but rs unused; rt used but different.
        @(negedge clk); clear_inputs(); set_load(3'd4); id_rs = 3'd4; id_rs_used = 1'b0; id_rt = 3'd1; id_rt_used = 1'b1; #1;
        if (ctl !== C_RUN) begin $display("FAIL load_use_unused_ctl: got %b expected %b", ctl, C_RUN); fails++; end
        tests++;
        if (stall_count !== 16'd2) begin $display("FAIL load_use_count_rt: got %0d expected 2", stall_count); fails++; end
        tests++;
        // Load that does not write a register is not a hazard.
        @(negedge clk); clear_inputs(); idex_mem_read = 1'b1; idex_wr_sel = 3'd6; id_rs = 3'd6; id_rs_used = 1'b1; #1;
        if (ctl !== C_RUN) begin $display("FAIL load_use_noregwrite_ctl: got %b expected %b", ctl, C_RUN); fails++; end
        tests++;
        @(negedge clk); clear_inputs(); #1;
        if (stall_count !== 16'd2) begin $display("FAIL load_use_count_final: got %0d expected 2", stall_count); fails++; end
        tests++;
    endtask

    task automatic test_branch_priority();
        @(negedge clk); clear_inputs(); set_load(3'd3); id_rs = 3'd3; id_rs_used = 1'b1; branch_taken = 1'b1; #1;
        if (ctl !== C_BR) begin $display("FAIL branch_vs_load_use_ctl: got %b expected %b", ctl, C_BR); fails++; end
        tests++;
        @(negedge clk); clear_inputs(); branch_taken = 1'b1; imem_stall = 1'b1; #1;
        if (ctl !== C_BR) begin $display("FAIL branch_vs_imem_ctl: got %b expected %b", ctl, C_BR); fails++; end
        tests++;
        if (stall_count !== 16'd2) begin $display("FAIL branch_count_unchanged: got %0d expected 2", stall_count); fails++; end
        tests++;
        @(negedge clk); clear_inputs(); imem_stall = 1'b1; #1;
        if (ctl !== C_IMEM) begin $display("FAIL imem_stall_ctl: got %b expected %b", ctl, C_IMEM); fails++; end
        tests++;
        if (stall_count !== 16'd2) begin $display("FAIL branch_count_after: got %0d expected 2", stall_count); fails++; end
        tests++;
        @(negedge clk); clear_inputs(); #1;
        if (stall_count !== 16'd3) begin $display("FAIL imem_count: got %0d expected 3", stall_count); fails++; end
        tests++;
    endtask

    task automatic test_mem_wait();
        // Starts with stall_count 3 in RUN; first cycle also has a taken branch.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); clear_inputs(); dmem_stall = 1'b1; branch_taken = (i == 0); #1;
            if (ctl !== C_HOLD) begin $display("FAIL mem_wait_ctl[%0d]: got %b expected %b", i, ctl, C_HOLD); fails++; end
            tests++;
        end
        @(negedge clk); clear_inputs(); #1;
        if (ctl !== C_RUN) begin $display("FAIL mem_wait_exit_ctl: got %b expected %b", ctl, C_RUN); fails++; end
        tests++;
        if (stall_count !== 16'd8 || err !== 1'b0) begin
            $display("FAIL mem_wait_status: got count=%0d err=%b expected count=8 err=0", stall_count, err); fails++;
        end
        tests++;
        @(negedge clk); set_load(3'd1); id_rt = 3'd1; id_rt_used = 1'b1; #1;
        if (ctl !== C_LU) begin $display("FAIL mem_wait_back_in_run_ctl: got %b expected %b", ctl, C_LU); fails++; end
        tests++;
        @(negedge clk); clear_inputs(); #1;
        if (stall_count !== 16'd9) begin $display("FAIL mem_wait_final_count: got %0d expected 9", stall_count); fails++; end
        tests++;
    endtask

    task automatic test_reset_mid_stall();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); clear_inputs(); dmem_stall = 1'b1; #1;
            if (stall_count !== 16'(9 + i)) begin
                $display("FAIL mid_stall_count[%0d]: got %0d expected %0d", i, stall_count, 9 + i); fails++;
            end
            tests++;
        end
        #2 rst = 1'b0;
        #1;
        if (stall_count !== 16'd0 || ctl !== C_RESET) begin
            $display("FAIL mid_stall_async_reset: got count=%0d ctl=%b expected count=0 ctl=%b", stall_count, ctl, C_RESET); fails++;
        end
        tests++;
        @(negedge clk); rst = 1'b1; clear_inputs(); #1;
        if (ctl !== C_RUN) begin $display("FAIL mid_stall_release_ctl: got %b expected %b", ctl, C_RUN); fails++; end
        tests++;
    endtask

    task automatic test_watchdog();
        // Fresh from reset: dut4 uses TIMEOUT=4.
        if (err4 !== 1'b0) begin $display("FAIL watchdog_initial_err: got %b expected 0", err4); fails++; end
        tests++;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk); clear_inputs(); dmem_stall = 1'b1; #1;
            if (err4 !== logic'(i >= 6)) begin
                $display("FAIL watchdog_err[%0d]: got %b expected %b", i, err4, logic'(i >= 6)); fails++;
            end
            tests++;
        end
        if (err !== 1'b0) begin $display("FAIL watchdog_default_timeout_err: got %b expected 0", err); fails++; end
        tests++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); clear_inputs(); #1;
            if (err4 !== 1'b1) begin $display("FAIL watchdog_sticky[%0d]: got %b expected 1", i, err4); fails++; end
            tests++;
        end
    endtask

    task automatic test_saturation();
        @(negedge clk); rst = 1'b0; clear_inputs();
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); clear_inputs(); imem_stall = 1'b1; #1;
            if (stallCountS !== 3'((i > 7) ? 7 : i)) begin
                $display("FAIL saturate_count[%0d]: got %0d expected %0d", i, stallCountS, (i > 7) ? 7 : i); fails++;
            end
            tests++;
        end
        @(negedge clk); clear_inputs(); #1;
        if (stallCountS !== 3'd7) begin $display("FAIL saturate_hold: got %0d expected 7", stallCountS); fails++; end
        tests++;
    endtask

    task automatic test_halt();
        @(negedge clk); rst = 1'b0; clear_inputs();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); halt_mem = 1'b1; dmem_stall = 1'b1; #1;
        if (ctl !== C_HOLD) begin $display("FAIL halt_entry_ctl: got %b expected %b", ctl, C_HOLD); fails++; end
        tests++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); clear_inputs(); branch_taken = i[0]; imem_stall = ~i[0]; #1;
            if (ctl !== C_HOLD) begin $display("FAIL halted_ctl[%0d]: got %b expected %b", i, ctl, C_HOLD); fails++; end
            tests++;
            if (stall_count !== 16'd1) begin $display("FAIL halted_count[%0d]: got %0d expected 1", i, stall_count); fails++; end
            tests++;
        end
        @(negedge clk); rst = 1'b0; #1;
        if (ctl !== C_RESET || stall_count !== 16'd0) begin
            $display("FAIL halt_reset: got ctl=%b count=%0d expected ctl=%b count=0", ctl, stall_count, C_RESET); fails++;
        end
        tests++;
        @(negedge clk); rst = 1'b1; clear_inputs(); #1;
        if (ctl !== C_RUN) begin $display("FAIL halt_release_ctl: got %b expected %b", ctl, C_RUN); fails++; end
        tests++;
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_load_use();
        test_branch_priority();
        test_mem_wait();
        test_reset_mid_stall();
        test_watchdog();
        test_saturation();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline control unit driving the write-enable and flush inputs of the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Detects load-use hazards, squashes wrong-path instructions on taken branches, freezes the pipeline on data-memory stalls, and parks the core on HALT.
- Keeps a saturating stall-cycle counter and a memory-wait watchdog whose expiry raises sticky err.
- Sits beside the register file and hazard logic in decode; consumes ID/EX and EX/MEM fields directly.

Parameters:
TIMEOUT, 64, max consecutive MEM_WAIT cycles before err is raised (legal range 2..2^CNT_W-1)
CNT_W, 16, width of stall counter and watchdog counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
id_rs  input  3  decode-stage source register 1
id_rt  input  3  decode-stage source register 2
id_rs_used  input  1  decode instruction reads id_rs
id_rt_used  input  1  decode instruction reads id_rt
idex_mem_read  input  1  instruction in EX is a load
idex_reg_write  input  1  instruction in EX writes a register
idex_wr_sel  input  3  destination register of instruction in EX
branch_taken  input  1  EX resolved a taken branch/jump this cycle
imem_stall  input  1  instruction memory not ready
dmem_stall  input  1  data memory busy
halt_mem  input  1  HALT instruction in MEM this cycle
pc_we  output  1  PC write enable
ifid_we  output  1  IF/ID write enable
ifid_flush  output  1  load NOP into IF/ID
idex_we  output  1  ID/EX write enable
idex_flush  output  1  load zero Ctrl (bubble) into ID/EX
exmem_we  output  1  EX/MEM and MEM/WB write enable
stall_count  output  CNT_W  saturating count of cycles with pc_we=0 outside HALTED
err  output  1  sticky error

Behaviour:
- States: RUN, MEM_WAIT, HALTED. Reset state RUN. Outputs Mealy: combinational from state + inputs.
- While rst=0: state RUN, stall_count=0, watchdog=0, err=0; pc_we=ifid_we=idex_we=exmem_we=0; ifid_flush=idex_flush=1.
- load_use = idex_mem_read & idex_reg_write & ((id_rs_used & id_rs==idex_wr_sel) | (id_rt_used & id_rt==idex_wr_sel)).
- RUN, priority high to low:
  1. halt_mem: all we=0, flushes=0; next HALTED.
  2. dmem_stall: all we=0, flushes=0; next MEM_WAIT; watchdog<=1.
  3. branch_taken: all we=1, ifid_flush=1, idex_flush=1. Beats load_use and imem_stall.
  4. load_use: pc_we=0, ifid_we=0, idex_we=1, idex_flush=1, exmem_we=1. One bubble; hazard clears next cycle as load advances.
  5. imem_stall: pc_we=0, ifid_we=1, ifid_flush=1, rest we=1.
  6. Otherwise: all we=1, flushes=0.
- MEM_WAIT: all we=0, flushes=0; hold until dmem_stall=0, then RUN (same cycle evaluates RUN rules combinationally? No: exit cycle outputs all we=1, flushes=0; hazards re-evaluated next cycle). Watchdog increments each MEM_WAIT cycle; at watchdog==TIMEOUT, err<=1 (sticky), FSM stays in MEM_WAIT.
- HALTED: all we=0, flushes=0; exit only via reset. stall_count frozen.
- stall_count increments on every clock with pc_we=0 in RUN or MEM_WAIT; saturates at all-ones, no wrap.
- Illegal state encoding: err<=1, next RUN.
- Reset asserted mid-stall: immediate async return to reset values; counts lost.

Test Plan:
- Reset: hold rst=0 three cycles -> all we=0, both flushes=1, stall_count=0, err=0; release -> RUN, all we=1.
- Load-use: idex_mem_read=1, idex_reg_write=1, idex_wr_sel=3, id_rs=3, id_rs_used=1 for one cycle -> pc_we=0, ifid_we=0, idex_flush=1 that cycle; stall_count 0->1; next cycle all we=1.
- Branch vs. load-use same cycle: both conditions true -> ifid_flush=1, idex_flush=1, pc_we=1; stall_count unchanged.
- Memory wait: dmem_stall=1 for 5 cycles -> all we=0 for 5 cycles; stall_count=5; err=0; RUN on drop.
- Watchdog: TIMEOUT=4, dmem_stall held 10 cycles -> err=1 after 4th MEM_WAIT cycle; stays 1 after stall drops.
- Halt: halt_mem=1 with dmem_stall=1 -> HALTED; all we=0 indefinitely; stall_count frozen; rst pulse returns to RUN.
